// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared encodings for the writeback stage (wb source, load size, FSM state).
package msrv32_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_CSR  = 2'b10,
        WB_PC4  = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef logic [0:0] wb_state_t;
    localparam wb_state_t ST_IDLE     = 1'b0;
    localparam wb_state_t ST_WAIT_MEM = 1'b1;

endpackage

// File: rtl/msrv32_writeback_stage_if.sv
// msrv32_writeback_stage_if: stage 2 -> stage 3 instruction handshake bundle.
interface msrv32_writeback_stage_if #(parameter int DATA_W = 32);
    logic              valid_in;
    logic              ready_out;
    logic [4:0]        rd_addr_in;
    logic              wr_en_req_in;
    logic [1:0]        wb_sel_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] csr_data_in;
    logic [DATA_W-1:0] pc_plus4_in;
    logic [1:0]        load_size_in;
    logic              load_unsigned_in;

    modport master (
        output valid_in, rd_addr_in, wr_en_req_in, wb_sel_in, alu_result_in,
               csr_data_in, pc_plus4_in, load_size_in, load_unsigned_in,
        input  ready_out
    );

    modport slave (
        input  valid_in, rd_addr_in, wr_en_req_in, wb_sel_in, alu_result_in,
               csr_data_in, pc_plus4_in, load_size_in, load_unsigned_in,
        output ready_out
    );
endinterface

// File: rtl/msrv32_load_align.sv
// msrv32_load_align: extracts and sign/zero-extends a byte, half or word from a read word.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  addr_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] data_out
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_in[{addr_in, 3'b000} +: 8];
    assign half_lane = addr_in[1] ? rdata_in[31:16] : rdata_in[15:0];

    // size 2'b11 falls through to word
    assign data_out = (size_in == LS_BYTE) ? {{24{~unsigned_in & byte_lane[7]}}, byte_lane} :
                      (size_in == LS_HALF) ? {{16{~unsigned_in & half_lane[15]}}, half_lane} :
                      rdata_in;
endmodule

// File: rtl/msrv32_writeback_stage.sv
// msrv32_writeback_stage: pipeline stage 3, selects writeback source and drives the register file.
// Define MSRV32_WB_RETIRE_CNT_EN to add the retired-instruction counter output.
module msrv32_writeback_stage
    import msrv32_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef MSRV32_WB_RETIRE_CNT_EN
    , parameter int RET_CNT_W = 64
`endif
) (
    input  logic                 clock,
    input  logic                 reset_in,
    msrv32_writeback_stage_if.slave s2,
    input  logic [DATA_W-1:0]    dmem_rdata_in,
    input  logic                 dmem_rvalid_in,
    output logic [4:0]           rd_addr_out,
    output logic                 wr_en_out,
    output logic [DATA_W-1:0]    rd_out,
    output logic                 retire_out,
    output logic                 pend_load_valid_out,
    output logic [4:0]           pend_load_rd_out
`ifdef MSRV32_WB_RETIRE_CNT_EN
    , output logic [RET_CNT_W-1:0] retire_count_out
`endif
);
    wb_state_t         state_q;
    logic [4:0]        ld_rd_q;
    logic              ld_wen_q;
    logic [1:0]        ld_size_q;
    logic              ld_uns_q;
    logic [1:0]        ld_addr_q;
    logic              hs;
    logic              take_op;
    logic              take_ld;
    logic              ld_done;
    logic              retire_d;
    logic              op_wen;
    logic [DATA_W-1:0] op_data;
    logic [DATA_W-1:0] load_data;

    assign s2.ready_out        = (state_q == ST_IDLE);
    assign hs                  = s2.valid_in && s2.ready_out;
    assign take_ld             = hs && (s2.wb_sel_in == WB_LOAD);
    assign take_op             = hs && (s2.wb_sel_in != WB_LOAD);
    assign ld_done             = (state_q == ST_WAIT_MEM) && dmem_rvalid_in;
    assign retire_d            = take_op || ld_done;
    assign op_wen              = s2.wr_en_req_in && (s2.rd_addr_in != 5'd0);
    assign pend_load_valid_out = (state_q == ST_WAIT_MEM);
    assign pend_load_rd_out    = pend_load_valid_out ? ld_rd_q : 5'd0;
    assign op_data = (s2.wb_sel_in == WB_CSR) ? s2.csr_data_in :
                     (s2.wb_sel_in == WB_PC4) ? s2.pc_plus4_in : s2.alu_result_in;

    msrv32_load_align u_align (
        .rdata_in    (dmem_rdata_in),
        .addr_in     (ld_addr_q),
        .size_in     (ld_size_q),
        .unsigned_in (ld_uns_q),
        .data_out    (load_data)
    );

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            ld_rd_q     <= 5'd0;
            ld_wen_q    <= 1'b0;
            ld_size_q   <= 2'd0;
            ld_uns_q    <= 1'b0;
            ld_addr_q   <= 2'd0;
            rd_addr_out <= 5'd0;
            wr_en_out   <= 1'b0;
            rd_out      <= '0;
            retire_out  <= 1'b0;
        end else begin
            wr_en_out  <= 1'b0;
            retire_out <= retire_d;
            if (take_ld) begin
                state_q   <= ST_WAIT_MEM;
                ld_rd_q   <= s2.rd_addr_in;
                ld_wen_q  <= op_wen;
                ld_size_q <= s2.load_size_in;
                ld_uns_q  <= s2.load_unsigned_in;
                ld_addr_q <= s2.alu_result_in[1:0];
            end else if (take_op) begin
                rd_addr_out <= s2.rd_addr_in;
                wr_en_out   <= op_wen;
                rd_out      <= op_data;
            end else if (ld_done) begin
                state_q     <= ST_IDLE;
                rd_addr_out <= ld_rd_q;
                wr_en_out   <= ld_wen_q;
                rd_out      <= load_data;
            end
        end
    end

`ifdef MSRV32_WB_RETIRE_CNT_EN
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) retire_count_out <= '0;
        else if (retire_d) retire_count_out <= retire_count_out + RET_CNT_W'(1);
    end
`endif
endmodule
